// File: rtl/md5_match_collector.sv
// ---------------------------------------------------------------------------
// md5_match_collector
//
// Result-side companion to the MD5 brute-force candidate counter. It takes
// the per-candidate compare results from the MD5 pipeline, queues the tags of
// matching candidates in a small show-ahead FIFO for software, counts hits
// (saturating at 255), records dropped hits in a sticky overflow flag, asks
// the counter to pause while the queue is full, and raises a sticky
// "finished" flag once the counter is done and the pipeline has drained.
//
// Parameters:
//   TAG_W  - candidate tag width (matches the counter output width)
//   DEPTH  - FIFO entries, power of two, >= 2
//   DRAIN  - cycles from counter done until the last result can arrive
//
// Ports:
//   CLK          in   clock, rising edge
//   reset        in   synchronous, active-high reset
//   hit_valid    in   compare result valid this cycle
//   hit          in   digest matched the target (qualified by hit_valid)
//   hit_tag      in   counter value that produced this digest
//   search_done  in   counter done flag (level)
//   stop_on_full in   when 1, hold asserts while the FIFO is full
//   pop          in   software read strobe, one cycle per entry
//   rd_tag       out  FIFO head (show-ahead), valid while rd_valid
//   rd_valid     out  FIFO not empty
//   match_count  out  total hits seen, saturates at 255
//   overflow     out  sticky: a hit was dropped because the FIFO was full
//   hold         out  pause request to the candidate counter
//   finished     out  sticky: search complete and pipeline drained
// ---------------------------------------------------------------------------
module md5_match_collector #(
  parameter int TAG_W = 31,
  parameter int DEPTH = 4,
  parameter int DRAIN = 68
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             hit_valid,
  input  logic             hit,
  input  logic [TAG_W-1:0] hit_tag,
  input  logic             search_done,
  input  logic             stop_on_full,
  input  logic             pop,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  output logic [7:0]       match_count,
  output logic             overflow,
  output logic             hold,
  output logic             finished
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(DRAIN) + 1;

  localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FIN   = 2'd2;

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;

  logic [1:0]       state;
  logic [CNT_W-1:0] drain_cnt;

  logic push;
  logic pop_eff;
  logic accept;

  assign push    = hit_valid & hit;
  assign pop_eff = pop & (occ != '0);
  // A push into a full FIFO is still accepted when the head leaves in the
  // same cycle: with a full queue wr_ptr == rd_ptr, so the new tag lands in
  // the slot being freed.
  assign accept  = push & ((occ != OCC_FULL) | pop_eff);

  // Pointers, occupancy and the statistics registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      match_count <= 8'd0;
      overflow    <= 1'b0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_eff)
        rd_ptr <= rd_ptr + PTR_W'(1);

      case ({accept, pop_eff})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase

      if (push && !accept)
        overflow <= 1'b1;
      // Every hit counts, including dropped ones; hold at 255.
      if (push && (match_count != 8'hFF))
        match_count <= match_count + 8'd1;
    end
  end

  // Tag storage; contents are never cleared, occupancy alone decides validity.
  always_ff @(posedge CLK) begin
    if (!reset && accept)
      mem[wr_ptr] <= hit_tag;
  end

  // Completion tracking: wait DRAIN cycles after done so every result still
  // in the MD5 pipeline has been collected before declaring the search over.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (search_done) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0)
            state <= ST_FIN;
          else
            drain_cnt <= drain_cnt - CNT_W'(1);
        end
        ST_FIN: begin
          state <= ST_FIN;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rd_tag   = mem[rd_ptr];
  assign rd_valid = (occ != '0);
  // Derived from registered occupancy only, so the counter enable path never
  // sees pop or hit_valid combinationally.
  assign hold     = stop_on_full & (occ == OCC_FULL);
  assign finished = (state == ST_FIN);

endmodule

// File: tb/tb_md5_match_collector.sv
// ---------------------------------------------------------------------------
// tb_md5_match_collector
//
// Directed, self-checking bench for md5_match_collector (TAG_W=31, DEPTH=4,
// DRAIN=68). Each task drives one scenario and checks the outputs against
// hand-computed values. Inputs change 1 time unit after a rising edge and
// outputs are checked at that same point, i.e. reflecting the edge just taken.
// ---------------------------------------------------------------------------
module tb_md5_match_collector;

  logic        CLK;
  logic        reset;
  logic        hit_valid;
  logic        hit;
  logic [30:0] hit_tag;
  logic        search_done;
  logic        stop_on_full;
  logic        pop;
  logic [30:0] rd_tag;
  logic        rd_valid;
  logic [7:0]  match_count;
  logic        overflow;
  logic        hold;
  logic        finished;

  int checks;
  int errors;

  md5_match_collector #(
    .TAG_W(31),
    .DEPTH(4),
    .DRAIN(68)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .hit_valid   (hit_valid),
    .hit         (hit),
    .hit_tag     (hit_tag),
    .search_done (search_done),
    .stop_on_full(stop_on_full),
    .pop         (pop),
    .rd_tag      (rd_tag),
    .rd_valid    (rd_valid),
    .match_count (match_count),
    .overflow    (overflow),
    .hold        (hold),
    .finished    (finished)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    hit_valid   = 1'b0;
    hit         = 1'b0;
    hit_tag     = '0;
    search_done = 1'b0;
    pop         = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Present one matching result for the next edge.
  task automatic drive_hit(input logic [30:0] tag);
    hit_valid = 1'b1;
    hit       = 1'b1;
    hit_tag   = tag;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    stop_on_full = 1'b1;
    do_reset();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (match_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_match_count: got %0d expected 0", match_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (hold !== 1'b0) begin errors++; $display("[TB] FAIL reset_hold: got %b expected 0", hold); end
    checks++; if (finished !== 1'b0) begin errors++; $display("[TB] FAIL reset_finished: got %b expected 0", finished); end
    // Pop while empty must be ignored.
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL empty_pop_rd_valid: got %b expected 0", rd_valid); end
    // A following push must appear as the head, proving rd_ptr did not move.
    drive_hit(31'h0AA);
    tick();
    idle_inputs();
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL empty_pop_then_push_valid: got %b expected 1", rd_valid); end
    checks++; if (rd_tag !== 31'h0AA) begin errors++; $display("[TB] FAIL empty_pop_then_push_tag: got %h expected 0aa", rd_tag); end
    // Push while empty with pop high: push taken, pop ignored.
    do_reset();
    drive_hit(31'h0BB);
    pop = 1'b1;
    tick();
    idle_inputs();
    checks++; if (rd_valid !== 1'b1 || rd_tag !== 31'h0BB) begin errors++; $display("[TB] FAIL push_pop_empty: got valid=%b tag=%h expected valid=1 tag=0bb", rd_valid, rd_tag); end
  endtask

  task automatic test_fifo_order();
    logic [30:0] exp_tags [3];
    $display("[TB] test_fifo_order");
    exp_tags[0] = 31'h10;
    exp_tags[1] = 31'h20;
    exp_tags[2] = 31'h30;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_hit(exp_tags[i]);
      tick();
      checks++; if (rd_tag !== 31'h10 || rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL order_head_during_push%0d: got valid=%b tag=%h expected valid=1 tag=10", i, rd_valid, rd_tag); end
    end
    // A non-matching result must not be queued or counted.
    hit_valid = 1'b1;
    hit       = 1'b0;
    hit_tag   = 31'h99;
    tick();
    idle_inputs();
    checks++; if (match_count !== 8'd3) begin errors++; $display("[TB] FAIL order_match_count: got %0d expected 3", match_count); end
    for (int i = 1; i <= 3; i++) begin
      pop = 1'b1;
      tick();
      pop = 1'b0;
      if (i < 3) begin
        checks++; if (rd_tag !== exp_tags[i] || rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL order_pop%0d: got valid=%b tag=%h expected valid=1 tag=%h", i, rd_valid, rd_tag, exp_tags[i]); end
      end else begin
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL order_drained: got valid=%b expected 0", rd_valid); end
      end
    end
  endtask

  task automatic test_full_overflow();
    $display("[TB] test_full_overflow");
    stop_on_full = 1'b1;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive_hit(31'(i));
      tick();
      if (i == 3) begin
        checks++; if (hold !== 1'b0) begin errors++; $display("[TB] FAIL full_hold_at3: got %b expected 0", hold); end
      end
      if (i == 4) begin
        checks++; if (hold !== 1'b1 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL full_hold_at4: got hold=%b ovf=%b expected hold=1 ovf=0", hold, overflow); end
      end
    end
    idle_inputs();
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL full_overflow: got %b expected 1", overflow); end
    checks++; if (match_count !== 8'd5) begin errors++; $display("[TB] FAIL full_match_count: got %0d expected 5", match_count); end
    checks++; if (rd_tag !== 31'h1) begin errors++; $display("[TB] FAIL full_head: got %h expected 1", rd_tag); end
    stop_on_full = 1'b0;
    #1;
    checks++; if (hold !== 1'b0) begin errors++; $display("[TB] FAIL full_hold_disabled: got %b expected 0", hold); end
    stop_on_full = 1'b1;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++; if (hold !== 1'b0 || overflow !== 1'b1) begin errors++; $display("[TB] FAIL full_after_pop: got hold=%b ovf=%b expected hold=0 ovf=1", hold, overflow); end
    checks++; if (rd_tag !== 31'h2) begin errors++; $display("[TB] FAIL full_after_pop_head: got %h expected 2", rd_tag); end
  endtask

  task automatic test_full_push_pop();
    logic [30:0] exp_tags [5];
    $display("[TB] test_full_push_pop");
    exp_tags[0] = 31'h0A1;
    exp_tags[1] = 31'h0A2;
    exp_tags[2] = 31'h0A3;
    exp_tags[3] = 31'h0A4;
    exp_tags[4] = 31'h055;
    stop_on_full = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_hit(exp_tags[i]);
      tick();
    end
    // Full: push 0x55 and pop together.
    drive_hit(31'h055);
    pop = 1'b1;
    tick();
    idle_inputs();
    checks++; if (hold !== 1'b1) begin errors++; $display("[TB] FAIL pushpop_still_full: got hold=%b expected 1", hold); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_overflow: got %b expected 0", overflow); end
    checks++; if (rd_tag !== exp_tags[1]) begin errors++; $display("[TB] FAIL pushpop_head: got %h expected %h", rd_tag, exp_tags[1]); end
    for (int i = 2; i <= 5; i++) begin
      pop = 1'b1;
      tick();
      pop = 1'b0;
      if (i <= 4) begin
        checks++; if (rd_tag !== exp_tags[i] || rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL pushpop_pop%0d: got valid=%b tag=%h expected valid=1 tag=%h", i, rd_valid, rd_tag, exp_tags[i]); end
      end else begin
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_empty: got %b expected 0", rd_valid); end
      end
    end
  endtask

  task automatic test_saturation();
    $display("[TB] test_saturation");
    do_reset();
    pop = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive_hit(31'(i));
      tick();
      if (i == 199) begin
        checks++; if (match_count !== 8'd200) begin errors++; $display("[TB] FAIL sat_count_200: got %0d expected 200", match_count); end
      end
    end
    idle_inputs();
    checks++; if (match_count !== 8'd255) begin errors++; $display("[TB] FAIL sat_count: got %0d expected 255", match_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL sat_overflow: got %b expected 0", overflow); end
    checks++; if (rd_valid !== 1'b1 || rd_tag !== 31'd299) begin errors++; $display("[TB] FAIL sat_head: got valid=%b tag=%0d expected valid=1 tag=299", rd_valid, rd_tag); end
  endtask

  task automatic test_completion();
    bit early;
    $display("[TB] test_completion");
    early = 1'b0;
    do_reset();
    search_done = 1'b1;
    tick();
    search_done = 1'b0;
    for (int k = 1; k <= 68; k++) begin
      if (k == 10)
        drive_hit(31'h077);
      else
        idle_inputs();
      tick();
      if (k < 68 && finished !== 1'b0)
        early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("[TB] FAIL done_early: got early=%b expected 0", early); end
    checks++; if (finished !== 1'b1) begin errors++; $display("[TB] FAIL done_at_68: got %b expected 1", finished); end
    checks++; if (rd_valid !== 1'b1 || rd_tag !== 31'h077) begin errors++; $display("[TB] FAIL done_hit_queued: got valid=%b tag=%h expected valid=1 tag=077", rd_valid, rd_tag); end
    for (int k = 0; k < 5; k++)
      tick();
    checks++; if (finished !== 1'b1) begin errors++; $display("[TB] FAIL done_sticky: got %b expected 1", finished); end
  endtask

  task automatic test_reset_during_drain();
    bit rose;
    $display("[TB] test_reset_during_drain");
    rose = 1'b0;
    stop_on_full = 1'b1;
    do_reset();
    search_done = 1'b1;
    tick();
    search_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_hit(31'(k + 100));
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 15; k++)
      tick();
    // Reset mid-drain with a hit and done presented in the reset cycle.
    reset = 1'b1;
    drive_hit(31'h123);
    search_done = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    checks++; if (match_count !== 8'd0 || overflow !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_clear: got cnt=%0d ovf=%b valid=%b expected 0/0/0", match_count, overflow, rd_valid); end
    for (int k = 0; k < 100; k++) begin
      tick();
      if (finished !== 1'b0)
        rose = 1'b1;
    end
    checks++; if (rose !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_finished: got rose=%b expected 0", rose); end
    // A fresh done from IDLE must again take exactly 68 cycles.
    search_done = 1'b1;
    tick();
    search_done = 1'b0;
    for (int k = 1; k <= 67; k++)
      tick();
    checks++; if (finished !== 1'b0) begin errors++; $display("[TB] FAIL restart_at_67: got %b expected 0", finished); end
    tick();
    checks++; if (finished !== 1'b1) begin errors++; $display("[TB] FAIL restart_at_68: got %b expected 1", finished); end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    stop_on_full = 1'b0;
    idle_inputs();
    test_reset();
    test_fifo_order();
    test_full_overflow();
    test_full_push_pop();
    test_saturation();
    test_completion();
    test_reset_during_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/md5_match_collector.md
# md5_match_collector

Result-side companion to the MD5 brute-force candidate counter. It receives per-candidate compare results from the MD5 core pipeline, each tagged with the candidate's counter value. It queues matching tags in a small show-ahead FIFO for software to read and keeps a saturating hit count and a sticky overflow flag. It returns a `hold` request that pauses the candidate counter when the queue is full, and flags completion once the counter reports done and the pipeline has drained.

## Interface
- `TAG_W`, 31: width of candidate tag; equals the counter output width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DRAIN`, 68: cycles from counter `done` until the last compare result can arrive; MD5 pipeline depth plus margin.

- `CLK` in 1: clock, all logic on rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `hit_valid` in 1: compare result valid this cycle.
- `hit` in 1: digest equals target; qualified by `hit_valid`.
- `hit_tag` in TAG_W: counter value that produced this digest.
- `search_done` in 1: counter `done` flag, level.
- `stop_on_full` in 1: config; when 1, `hold` asserts while FIFO full.
- `pop` in 1: software read strobe, one cycle per entry.
- `rd_tag` out TAG_W: FIFO head, valid while `rd_valid`.
- `rd_valid` out 1: FIFO not empty.
- `match_count` out 8: total hits seen, saturates at 255.
- `overflow` out 1: sticky; a hit was dropped because the FIFO was full.
- `hold` out 1: pause request to the counter; drives its enable low.
- `finished` out 1: sticky; search complete and pipeline drained.

## Operation
- Storage: `DEPTH`-entry register array, write pointer, read pointer, occupancy `occ` of width log2(DEPTH)+1.
- push = `hit_valid & hit`. accept = push & (occ<DEPTH | pop_eff). pop_eff = `pop` & (occ>0).
- Push accepted: write `hit_tag` at wr_ptr, wr_ptr+1 mod DEPTH.
- pop_eff: rd_ptr+1 mod DEPTH. `pop` while empty is ignored with no pointer change.
- Simultaneous push and pop_eff: occ unchanged, both pointers advance. When full, this is legal and the push is accepted.
- Push while empty with `pop` high: push accepted, pop ignored, occ becomes 1.
- Push rejected (full, no pop): tag dropped, `overflow` set to 1 and held until reset.
- `match_count` increments on every push, accepted or dropped, and holds at 255.
- `rd_tag` = mem[rd_ptr], show-ahead. `rd_valid` = occ≠0.
- `hold` = `stop_on_full` & (occ==DEPTH), from registered occ. It must not combinationally depend on `pop` or `hit_valid`.
- Completion FSM, states IDLE, DRAIN, FIN:
  - IDLE: on `search_done`=1, go to DRAIN and load drain counter with `DRAIN`-1.
  - DRAIN: decrement each cycle. At 0, go to FIN. Results arriving during DRAIN are processed normally.
  - FIN: `finished`=1 and stays set until `reset`; `search_done` dropping does not clear it.
- Reset mid-operation: pointers, occ, `match_count`, `overflow`, `finished`, FSM→IDLE, all in the same edge. Array contents need not be cleared. Inputs in the reset cycle are ignored.

## Timing
- Reset values: `rd_valid`=0, `match_count`=0, `overflow`=0, `hold`=0, `finished`=0. `rd_tag` is don't-care while `rd_valid`=0.
- Push at edge N: `rd_valid`/`rd_tag` update after edge N, with 1-cycle latency to visibility.
- `pop` at edge N: next entry, or `rd_valid`=0, visible after edge N.
- `hold` rises the cycle after the push that fills the FIFO. The counter may advance one more candidate, and its result must still be accepted or counted as overflow.
- `finished` rises exactly `DRAIN` cycles after the first edge with `search_done`=1 sampled.
- Counter arithmetic: occ, pointers, and drain counter wrap by modulus only. `match_count` saturates and never wraps.

## Test plan
- Reset then idle: all outputs 0. Assert `pop` while empty: occ stays 0, no pointer change.
- Push tags 0x10, 0x20, 0x30 on consecutive cycles, then pop 3 times: `rd_tag` 0x10→0x20→0x30, then `rd_valid`=0, `match_count`=3.
- DEPTH=4, `stop_on_full`=1, 5 hits without pop: `hold`=1 after the 4th push, 5th push dropped, `overflow`=1, `match_count`=5. One pop: `hold`=0 next cycle, `overflow` stays 1.
- Full FIFO, push 0x55 and pop in the same cycle: occ stays 4, 0x55 is read as the 4th entry after 3 more pops, `overflow`=0.
- 300 hits with continuous pop: `match_count`=255, no overflow.
- `search_done` pulsed 1 cycle with `DRAIN`=68: `finished`=1 exactly 68 cycles later and sticky. A hit arriving 10 cycles after done is queued. Assert `reset` during DRAIN: `finished` never rises, FSM returns to IDLE.
